// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory write port: FSM encoding,
// arbitration grant record, address word mask and the watchdog poison word.
package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        LD   = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_ST = 1'b0,
        GRANT_LD = 1'b1
    } grant_t;

    // Returned as load data when the watchdog aborts a load.
    localparam logic [31:0] POISON_DATA    = 32'hDEAD_BEEF;
    localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;
    localparam int          WDOG_CNT_W     = 8;

    function automatic logic is_bus_state(state_t s);
        return (s == WR) || (s == LD);
    endfunction

endpackage

// File: rtl/mem_write_port_if.sv
// Store-buffer, load and memory-bus signals of mem_write_port, bundled so the
// port and its environment connect through a single interface instance.
interface mem_write_port_if;

    logic        sb_valid;
    logic [31:0] sb_addr;
    logic [31:0] sb_data;
    logic [3:0]  sb_byte_en;
    logic        sb_ready;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_done;
    logic [31:0] ld_data;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        err_timeout;

    // Environment side: store buffer, load requester and memory model.
    modport master (
        output sb_valid, sb_addr, sb_data, sb_byte_en,
        input  sb_ready,
        output ld_req, ld_addr,
        input  ld_done, ld_data,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata,
        input  err_timeout
    );

    // The write port itself.
    modport slave (
        input  sb_valid, sb_addr, sb_data, sb_byte_en,
        output sb_ready,
        input  ld_req, ld_addr,
        output ld_done, ld_data,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata,
        output err_timeout
    );

endinterface

// File: rtl/mem_wdog.sv
// Bus watchdog: counts stalled bus cycles and flags expiry on the cycle that
// would be the MAX_WAIT-th one without an acknowledge.
module mem_wdog
    import mem_port_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam logic [WDOG_CNT_W-1:0] LAST_COUNT = WDOG_CNT_W'(MAX_WAIT - 1);

    logic [WDOG_CNT_W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (active) begin
            count <= count + 1'b1;
        end
    end

    // Expiry lands in the last permitted cycle so bus_req is held exactly MAX_WAIT cycles.
    assign expired = active && (count == LAST_COUNT);

endmodule

// File: rtl/mem_write_port.sv
// Memory write port: arbitrates store-buffer drains against loads onto a single
// request/ack memory bus. Optional watchdog abort under MEM_WRITE_PORT_WDOG_EN.
module mem_write_port
    import mem_port_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_write_port_if.slave  mp
);

    if (MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("mem_write_port: MAX_WAIT must be within 2..255");
    end

    state_t      state;
    state_t      state_next;
    grant_t      last_grant;
    logic        grant_st;
    logic        grant_ld;
    logic        wdog_expired;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] ld_data_q;

    // Arbitration: a sole requester wins; on a tie, alternate starting with the load.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        grant_st = 1'b0;
        grant_ld = 1'b0;
        if (state == IDLE) begin
            if (mp.ld_req && (!mp.sb_valid || last_grant == GRANT_ST)) begin
                grant_ld = 1'b1;
            end else if (mp.sb_valid) begin
                grant_st = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_ld) begin
                    state_next = LD;
                end else if (grant_st) begin
                    state_next = WR;
                end
            end
            WR: begin
                if (mp.bus_ack || wdog_expired) begin
                    state_next = IDLE;
                end
            end
            LD: begin
                if (mp.bus_ack || wdog_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture and load-data return. These registers drive bus outputs
    // directly, so they carry a defined reset value rather than X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= GRANT_ST;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            ld_data_q  <= '0;
        end else begin
            if (grant_st) begin
                last_grant <= GRANT_ST;
                addr_q     <= mp.sb_addr & ADDR_WORD_MASK;
                wdata_q    <= mp.sb_data;
                be_q       <= mp.sb_byte_en;
            end else if (grant_ld) begin
                last_grant <= GRANT_LD;
                addr_q     <= mp.ld_addr & ADDR_WORD_MASK;
                be_q       <= 4'b1111;
            end

            if (state == LD) begin
                if (mp.bus_ack) begin
                    ld_data_q <= mp.bus_rdata;
                end else if (wdog_expired) begin
                    ld_data_q <= POISON_DATA;
                end
            end
        end
    end

`ifdef MEM_WRITE_PORT_WDOG_EN
    logic err_timeout_q;
    logic wdog_clear;
    logic wdog_active;

    // Restart on every state change so each bus phase gets a full MAX_WAIT budget.
    assign wdog_clear  = (state != state_next);
    assign wdog_active = is_bus_state(state) && !mp.bus_ack;

    mem_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wdog_clear),
        .active  (wdog_active),
        .expired (wdog_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout_q <= 1'b0;
        end else if (wdog_expired) begin
            err_timeout_q <= 1'b1;
        end
    end

    assign mp.err_timeout = err_timeout_q;
`else
    assign wdog_expired   = 1'b0;
    assign mp.err_timeout = 1'b0;
`endif

    // Bus control comes straight from the state flop, so reset removes it at once.
    assign mp.sb_ready  = grant_st;
    assign mp.bus_req   = is_bus_state(state);
    assign mp.bus_we    = (state == WR);
    assign mp.bus_addr  = addr_q;
    assign mp.bus_wdata = wdata_q;
    assign mp.bus_be    = be_q;
    assign mp.ld_done   = (state == RESP);
    assign mp.ld_data   = ld_data_q;

endmodule
